// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock); optional signed mode via BCD_SIGNED_EN.
// Latency: WIDTH+1 cycles from the start-accept edge to the done pulse; busy is high for WIDTH of those cycles.
// Backpressure: none queued; start is honoured only in IDLE and ignored while a conversion is in flight.
module bcd_convert_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  hz100,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       mag_q, mag_d;
  logic [4*DIGITS-1:0]    scratch_q, scratch_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic [4*DIGITS-1:0]    adj;
  logic [4*DIGITS+WIDTH-1:0] sh;
`ifdef BCD_SIGNED_EN
  logic                   sign_q, sign_d;
  logic                   neg_q, neg_d;
`endif

  // Next-state, datapath and output computation; the displayed result only moves in DONE.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    count_d   = count_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    adj       = scratch_q;
    sh        = '0;
`ifdef BCD_SIGNED_EN
    sign_d    = sign_q;
    neg_d     = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef BCD_SIGNED_EN
          // Two's complement magnitude; the most negative value maps to 2**(WIDTH-1) unsigned.
          sign_d = bin[WIDTH-1];
          mag_d  = bin[WIDTH-1] ? (~bin + WIDTH'(1)) : bin;
`else
          mag_d  = bin;
`endif
          scratch_d = '0;
          count_d   = CW'(WIDTH);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
        // Digits >= 5 get +3 before the shift so that doubling carries correctly into the next digit.
        for (int i = 0; i < DIGITS; i++) begin
          if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
          end
        end
        sh                 = {adj, mag_q} << 1;
        {scratch_d, mag_d} = sh;
        count_d            = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d   = scratch_q;
`ifdef BCD_SIGNED_EN
        neg_d   = sign_q;
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset also clears the held result.
  always_ff @(posedge hz100) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mag_q     <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
`ifdef BCD_SIGNED_EN
      sign_q    <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
`ifdef BCD_SIGNED_EN
      sign_q    <= sign_d;
      neg_q     <= neg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
`ifdef BCD_SIGNED_EN
  assign neg  = neg_q;
`else
  assign neg  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Self-checking bench for bcd_convert_seq: directed table, hand-written corner sequences, random values.
// Inputs are driven and outputs sampled on the falling edge of hz100.
// Expected results come from a decimal-digit reference model (repeated division by ten).
module tb_bcd_convert_seq;

  logic        hz100;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic        neg;

  int checks = 0;
  int errors = 0;

  bcd_convert_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .hz100 (hz100),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .neg   (neg)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        neg;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] ref_digits(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic ref_model(input logic [15:0] b, output logic [19:0] eb, output logic en);
`ifdef BCD_SIGNED_EN
    if (b[15]) begin
      en = 1'b1;
      eb = ref_digits(65536 - int'(b));
    end else begin
      en = 1'b0;
      eb = ref_digits(int'(b));
    end
`else
    en = 1'b0;
    eb = ref_digits(int'(b));
`endif
  endtask

  // Called at a falling edge. Returns the result, the done latency in edges after the accept edge,
  // whether busy was high every cycle before done (and low at done), and whether bcd stayed put.
  task automatic run_conv(input logic [15:0] b, output logic [19:0] rb, output logic rn,
                          output int lat, output logic busy_ok, output logic held_ok);
    logic [19:0] prev;
    prev    = bcd;
    busy_ok = 1'b1;
    held_ok = 1'b1;
    lat     = -1;
    rb      = '0;
    rn      = 1'b0;
    start   = 1'b1;
    bin     = b;
    @(negedge hz100);
    start = 1'b0;
    bin   = 16'($urandom);
    if (busy !== 1'b0) busy_ok = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge hz100);
      if (done === 1'b1) begin
        lat = n;
        rb  = bcd;
        rn  = neg;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (bcd !== prev) held_ok = 1'b0;
    end
  endtask

  task automatic conv_and_check(input string name, input logic [15:0] b,
                                input logic [19:0] eb, input logic en);
    logic [19:0] rb;
    logic        rn;
    int          lat;
    logic        bok, hok;
    run_conv(b, rb, rn, lat, bok, hok);
    chk({name, "_latency"}, 32'(lat), 32'd17);
    chk({name, "_bcd"}, {12'h0, rb}, {12'h0, eb});
    chk({name, "_neg"}, {31'h0, rn}, {31'h0, en});
    chk({name, "_busy"}, {31'h0, bok}, 32'd1);
    chk({name, "_held"}, {31'h0, hok}, 32'd1);
    @(negedge hz100);
    chk({name, "_done_pulse"}, {31'h0, done}, 32'd0);
  endtask

  initial begin
    logic [19:0] eb;
    logic        en;
    logic [19:0] got;
    int          pulses;

`ifdef BCD_SIGNED_EN
    tbl[0] = '{16'h0000, 20'h00000, 1'b0};
    tbl[1] = '{16'hFFFF, 20'h00001, 1'b1};
    tbl[2] = '{16'h8000, 20'h32768, 1'b1};
    tbl[3] = '{16'h7FFF, 20'h32767, 1'b0};
    tbl[4] = '{16'h1234, 20'h04660, 1'b0};
    tbl[5] = '{16'hFF9C, 20'h00100, 1'b1};
`else
    tbl[0] = '{16'h0000, 20'h00000, 1'b0};
    tbl[1] = '{16'hFE01, 20'h65025, 1'b0};
    tbl[2] = '{16'hFFFF, 20'h65535, 1'b0};
    tbl[3] = '{16'h8000, 20'h32768, 1'b0};
    tbl[4] = '{16'h03E7, 20'h00999, 1'b0};
    tbl[5] = '{16'h2710, 20'h10000, 1'b0};
`endif

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(negedge hz100);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_bcd",  {12'h0, bcd}, 32'd0);
    chk("rst_neg",  {31'h0, neg}, 32'd0);
    reset = 1'b0;
    @(negedge hz100);

    for (int i = 0; i < 6; i++) begin
      conv_and_check($sformatf("tbl%0d", i), tbl[i].bin, tbl[i].bcd, tbl[i].neg);
    end

    // Second start mid-conversion is dropped; exactly one done pulse with the first value.
    pulses = 0;
    got    = '0;
    start  = 1'b1;
    bin    = 16'h1234;
    @(negedge hz100);
    start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 5) begin
        start = 1'b1;
        bin   = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(negedge hz100);
      if (done === 1'b1) begin
        pulses++;
        got = bcd;
      end
    end
    chk("ignore_start_pulses", 32'(pulses), 32'd1);
    chk("ignore_start_bcd", {12'h0, got}, 32'h04660);

    // Start presented while in DONE is ignored: no new conversion follows.
    start = 1'b1;
    bin   = 16'h0042;
    @(negedge hz100);
    start = 1'b0;
    repeat (16) @(negedge hz100);
    start = 1'b1;
    bin   = 16'h0007;
    @(negedge hz100);
    start = 1'b0;
    chk("done_state_done", {31'h0, done}, 32'd1);
    chk("done_state_bcd", {12'h0, bcd}, 32'h00066);
    @(negedge hz100);
    chk("done_state_busy1", {31'h0, busy}, 32'd0);
    @(negedge hz100);
    chk("done_state_busy2", {31'h0, busy}, 32'd0);

    // Reset mid-conversion aborts and clears the held result; no done follows.
    start = 1'b1;
    bin   = 16'h03E7;
    @(negedge hz100);
    start = 1'b0;
    repeat (7) @(negedge hz100);
    reset = 1'b1;
    @(negedge hz100);
    reset = 1'b0;
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_bcd", {12'h0, bcd}, 32'd0);
    pulses = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge hz100);
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    conv_and_check("after_abort", 16'h0009, 20'h00009, 1'b0);

    // Reset and start together: reset wins.
    reset = 1'b1;
    start = 1'b1;
    bin   = 16'h0055;
    @(negedge hz100);
    reset = 1'b0;
    start = 1'b0;
    @(negedge hz100);
    chk("rst_start_busy", {31'h0, busy}, 32'd0);

    for (int i = 0; i < 30; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if (i == 0) r = 16'h8000;
      if (i == 1) r = 16'h7FFF;
      ref_model(r, eb, en);
      conv_and_check($sformatf("rand%0d_%h", i, r), r, eb, en);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
